axi4_dma_write: RTL and testbench

AXI4 write-side DMA engine, the counterpart of the existing AXI4 DMA read engine. On an ap_start pulse it issues a programmed sequence of INCR write bursts of deterministic 512-bit data to host/HBM memory and collects every write response. It sits at the AXI4 master port with the same ap_ctrl handshake and control set as the read engine. It is used for write-bandwidth and latency measurement.

---
 rtl/axi4_dma_write.sv | 202 ++++++++++++++++++++
 tb/tb_axi4_dma_write.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_dma_write.sv
// AXI4 write-side DMA engine: issues a programmed sequence of INCR bursts of
// deterministic beat-index data and collects every write response.
module axi4_dma_write #(
  parameter int unsigned DATA_BYTES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      io_axi_awvalid,
  input  logic                      io_axi_awready,
  output logic [63:0]               io_axi_awaddr,
  output logic                      io_axi_awid,
  output logic [7:0]                io_axi_awlen,
  output logic [2:0]                io_axi_awsize,
  output logic [1:0]                io_axi_awburst,
  output logic                      io_axi_wvalid,
  input  logic                      io_axi_wready,
  output logic [DATA_BYTES*8-1:0]   io_axi_wdata,
  output logic [DATA_BYTES-1:0]     io_axi_wstrb,
  output logic                      io_axi_wlast,
  input  logic                      io_axi_bvalid,
  output logic                      io_axi_bready,
  input  logic                      io_axi_bid,
  input  logic [1:0]                io_axi_bresp,
  input  logic [63:0]               io_start_addr,
  input  logic [7:0]                io_len_burst,
  input  logic [31:0]               io_num_burst,
  input  logic [7:0]                io_stride,
  output logic [31:0]               io_cnt_clk,
  output logic [31:0]               io_cnt_err,
  input  logic                      io_ap_start,
  output logic                      io_ap_ready,
  output logic                      io_ap_done,
  output logic                      io_ap_idle
);

  localparam int unsigned DATA_W    = DATA_BYTES * 8;
  localparam int unsigned SIZE_LOG2 = $clog2(DATA_BYTES);
  localparam int unsigned REP       = DATA_W / 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic          r_done;
  logic          r_idle;
  logic          w_awvalid_nxt;
  logic          w_wvalid_nxt;
  logic          w_bready_nxt;
  logic          w_done_nxt;
  logic          w_idle_nxt;

  logic [63:0]   r_awaddr;
  logic [7:0]    r_len;
  logic [31:0]   r_num;
  logic [7:0]    r_stride;
  logic [31:0]   r_burst_cnt;
  logic [7:0]    r_beat;
  logic [31:0]   r_beat_idx;
  logic          r_wlast;
  logic [31:0]   r_cnt_clk;
  logic [31:0]   r_cnt_err;

  logic          w_start_acc;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_last_burst;
  logic [63:0]   w_stride_bytes;
  logic          w_unused;

  assign w_start_acc    = (r_state == S_IDLE) && io_ap_start;
  assign w_aw_hs        = r_awvalid && io_axi_awready;
  assign w_w_hs         = r_wvalid && io_axi_wready;
  assign w_b_hs         = r_bready && io_axi_bvalid;
  assign w_last_burst   = (r_burst_cnt == (r_num - 32'd1));
  assign w_stride_bytes = 64'(r_stride) << SIZE_LOG2;
  assign w_unused       = io_axi_bid;

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_ap_start) begin
          w_state_nxt = (io_num_burst == 32'd0) ? S_FIN : S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_aw_hs) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_w_hs && r_wlast) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_b_hs) w_state_nxt = w_last_burst ? S_FIN : S_ADDR;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_awvalid_nxt = (w_state_nxt == S_ADDR);
    w_wvalid_nxt  = (w_state_nxt == S_DATA);
    w_bready_nxt  = (w_state_nxt == S_RESP);
    w_done_nxt    = (w_state_nxt == S_FIN);
    w_idle_nxt    = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_done    <= w_done_nxt;
      r_idle    <= w_idle_nxt;
    end
  end

  // Job parameters, address/beat tracking and measurement counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_awaddr    <= 64'd0;
      r_len       <= 8'd0;
      r_num       <= 32'd0;
      r_stride    <= 8'd0;
      r_burst_cnt <= 32'd0;
      r_beat      <= 8'd0;
      r_beat_idx  <= 32'd0;
      r_wlast     <= 1'b0;
      r_cnt_clk   <= 32'd0;
      r_cnt_err   <= 32'd0;
    end else if (w_start_acc) begin
      r_awaddr    <= io_start_addr;
      r_len       <= io_len_burst;
      r_num       <= io_num_burst;
      r_stride    <= io_stride;
      r_burst_cnt <= 32'd0;
      r_beat      <= 8'd0;
      r_beat_idx  <= 32'd0;
      r_wlast     <= 1'b0;
      r_cnt_clk   <= 32'd0;
      r_cnt_err   <= 32'd0;
    end else begin
      if (r_state != S_IDLE) r_cnt_clk <= r_cnt_clk + 32'd1;

      // wlast is precomputed so it is valid on the first beat of a burst
      if (w_aw_hs) r_wlast <= (r_len == 8'd0);

      if (w_w_hs) begin
        r_beat_idx <= r_beat_idx + 32'd1;
        if (r_wlast) begin
          r_beat  <= 8'd0;
          r_wlast <= 1'b0;
        end else begin
          r_beat  <= r_beat + 8'd1;
          r_wlast <= ((r_beat + 8'd1) == r_len);
        end
      end

      if (w_b_hs) begin
        r_burst_cnt <= r_burst_cnt + 32'd1;
        r_awaddr    <= r_awaddr + w_stride_bytes;
        if (io_axi_bresp != 2'b00) r_cnt_err <= r_cnt_err + 32'd1;
      end
    end
  end

  assign io_axi_awvalid = r_awvalid;
  assign io_axi_awaddr  = r_awaddr;
  assign io_axi_awid    = 1'b0;
  assign io_axi_awlen   = r_len;
  assign io_axi_awsize  = 3'(SIZE_LOG2);
  assign io_axi_awburst = 2'b01;
  assign io_axi_wvalid  = r_wvalid;
  assign io_axi_wdata   = {REP{r_beat_idx}};
  assign io_axi_wstrb   = {DATA_BYTES{1'b1}};
  assign io_axi_wlast   = r_wlast;
  assign io_axi_bready  = r_bready;
  assign io_cnt_clk     = r_cnt_clk;
  assign io_cnt_err     = r_cnt_err;
  assign io_ap_ready    = r_done;
  assign io_ap_done     = r_done;
  assign io_ap_idle     = r_idle;

endmodule

// File: tb/tb_axi4_dma_write.sv
// Bench for axi4_dma_write: randomized slave backpressure and job parameters,
// checked against a burst/beat arithmetic model of the expected AXI traffic.
module tb_axi4_dma_write;

  logic         clk = 1'b0;
  logic         reset;
  logic         io_axi_awvalid, io_axi_awready;
  logic [63:0]  io_axi_awaddr;
  logic         io_axi_awid;
  logic [7:0]   io_axi_awlen;
  logic [2:0]   io_axi_awsize;
  logic [1:0]   io_axi_awburst;
  logic         io_axi_wvalid, io_axi_wready;
  logic [511:0] io_axi_wdata;
  logic [63:0]  io_axi_wstrb;
  logic         io_axi_wlast;
  logic         io_axi_bvalid, io_axi_bready, io_axi_bid;
  logic [1:0]   io_axi_bresp;
  logic [63:0]  io_start_addr;
  logic [7:0]   io_len_burst;
  logic [31:0]  io_num_burst;
  logic [7:0]   io_stride;
  logic [31:0]  io_cnt_clk, io_cnt_err;
  logic         io_ap_start, io_ap_ready, io_ap_done, io_ap_idle;

  always #5 clk = ~clk;

  axi4_dma_write #(.DATA_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .io_axi_awvalid(io_axi_awvalid), .io_axi_awready(io_axi_awready),
    .io_axi_awaddr(io_axi_awaddr), .io_axi_awid(io_axi_awid),
    .io_axi_awlen(io_axi_awlen), .io_axi_awsize(io_axi_awsize),
    .io_axi_awburst(io_axi_awburst),
    .io_axi_wvalid(io_axi_wvalid), .io_axi_wready(io_axi_wready),
    .io_axi_wdata(io_axi_wdata), .io_axi_wstrb(io_axi_wstrb),
    .io_axi_wlast(io_axi_wlast),
    .io_axi_bvalid(io_axi_bvalid), .io_axi_bready(io_axi_bready),
    .io_axi_bid(io_axi_bid), .io_axi_bresp(io_axi_bresp),
    .io_start_addr(io_start_addr), .io_len_burst(io_len_burst),
    .io_num_burst(io_num_burst), .io_stride(io_stride),
    .io_cnt_clk(io_cnt_clk), .io_cnt_err(io_cnt_err),
    .io_ap_start(io_ap_start), .io_ap_ready(io_ap_ready),
    .io_ap_done(io_ap_done), .io_ap_idle(io_ap_idle)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Job model: latched parameters and traffic observed so far
  logic [63:0] m_addr;
  int          m_len, m_num, m_stride;
  int          aw_n, w_k, b_n, exp_err, done_n, busy, done_cyc, wlast_n, c0;
  logic [63:0] last_awaddr;
  bit          mon_en = 1'b0;

  // Slave control
  bit          bp = 1'b0;
  bit          err_rand = 1'b0;
  logic [31:0] err_mask = 32'd0;
  int          pending_b = 0;
  bit          b_fire = 1'b0;
  bit          slv_clr = 1'b0;

  // Stall bookkeeping
  bit           aw_stall, w_stall;
  logic [63:0]  prev_awaddr;
  logic [7:0]   prev_awlen;
  logic [511:0] prev_wdata;
  logic         prev_wlast;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI slave: readies and write responses change just after the clock edge
  initial begin
    io_axi_awready = 1'b0;
    io_axi_wready  = 1'b0;
    io_axi_bvalid  = 1'b0;
    io_axi_bresp   = 2'b00;
    io_axi_bid     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (slv_clr) begin
        io_axi_bvalid = 1'b0;
        pending_b     = 0;
        b_fire        = 1'b0;
        slv_clr       = 1'b0;
      end
      io_axi_awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      io_axi_wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_fire) begin
        io_axi_bvalid = 1'b0;
        b_fire        = 1'b0;
      end
      if (!io_axi_bvalid && pending_b > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
        io_axi_bvalid = 1'b1;
        if (err_rand) io_axi_bresp = 2'($urandom_range(0, 3));
        else          io_axi_bresp = err_mask[b_n[4:0]] ? 2'b10 : 2'b00;
      end
    end
  end

  // Monitor: handshakes are settled at the falling edge and fire at the next rise
  always @(negedge clk) begin
    if (mon_en) begin
      int bi;
      if (!io_ap_idle) busy++;
      if (io_ap_done || io_ap_ready) begin
        chk("ready_eq_done", 512'(io_ap_ready), 512'(io_ap_done));
        if (io_ap_done) begin
          done_n++;
          done_cyc = cyc;
        end
      end
      if (aw_stall) chk("aw_stable", 512'({io_axi_awvalid, io_axi_awaddr, io_axi_awlen}),
                        512'({1'b1, prev_awaddr, prev_awlen}));
      if (w_stall) begin
        chk("w_stable_ctl", 512'({io_axi_wvalid, io_axi_wlast}), 512'({1'b1, prev_wlast}));
        chk("w_stable_data", io_axi_wdata, prev_wdata);
      end
      if (io_axi_awvalid && io_axi_awready) begin
        chk("awaddr", 512'(io_axi_awaddr),
            512'(m_addr + 64'(aw_n) * 64'(m_stride) * 64'd64));
        chk("awlen", 512'(io_axi_awlen), 512'(m_len));
        chk("aw_const", 512'({io_axi_awid, io_axi_awsize, io_axi_awburst}),
            512'({1'b0, 3'd6, 2'b01}));
        chk("aw_after_b", 512'(b_n), 512'(aw_n));
        last_awaddr = io_axi_awaddr;
        aw_n++;
      end
      if (io_axi_wvalid && io_axi_wready) begin
        logic [31:0] idx;
        bi  = w_k / (m_len + 1);
        idx = 32'(w_k);
        chk("wdata", io_axi_wdata, {16{idx}});
        chk("wlast", 512'(io_axi_wlast), 512'((w_k % (m_len + 1)) == m_len));
        chk("w_order", 512'({aw_n, b_n}), 512'({bi + 1, bi}));
        chk("wstrb", 512'(io_axi_wstrb), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        if (io_axi_wlast) begin
          pending_b++;
          wlast_n++;
        end
        w_k++;
      end
      if (io_axi_bvalid && io_axi_bready) begin
        if (io_axi_bresp != 2'b00) exp_err++;
        b_n++;
        pending_b--;
        b_fire = 1'b1;
      end
      aw_stall    = io_axi_awvalid && !io_axi_awready;
      prev_awaddr = io_axi_awaddr;
      prev_awlen  = io_axi_awlen;
      w_stall     = io_axi_wvalid && !io_axi_wready;
      prev_wdata  = io_axi_wdata;
      prev_wlast  = io_axi_wlast;
    end
  end

  task automatic launch(input logic [63:0] a, input int len, input int num, input int stride);
    aw_n = 0; w_k = 0; b_n = 0; exp_err = 0; done_n = 0; busy = 0; wlast_n = 0;
    done_cyc = -1; aw_stall = 1'b0; w_stall = 1'b0;
    m_addr = a; m_len = len; m_num = num; m_stride = stride;
    io_start_addr = a;
    io_len_burst  = 8'(len);
    io_num_burst  = 32'(num);
    io_stride     = 8'(stride);
    mon_en = 1'b1;
    @(posedge clk); #1;
    io_ap_start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    io_ap_start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    for (int i = 0; i < 4000 && done_n == 0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, 512'(done_n > 0), 512'(1));
    repeat (3) @(negedge clk);
    chk({tag, "_aw_cnt"}, 512'(aw_n), 512'(m_num));
    chk({tag, "_beats"}, 512'(w_k), 512'(m_num * (m_len + 1)));
    chk({tag, "_b_cnt"}, 512'(b_n), 512'(m_num));
    chk({tag, "_done_once"}, 512'(done_n), 512'(1));
    chk({tag, "_cnt_clk"}, 512'(io_cnt_clk), 512'(busy));
    chk({tag, "_cnt_err"}, 512'(io_cnt_err), 512'(exp_err));
    chk({tag, "_idle"}, 512'(io_ap_idle), 512'(1));
  endtask

  task automatic wait_wvalid(input string tag);
    for (int i = 0; i < 200 && !io_axi_wvalid; i++) @(negedge clk);
    chk({tag, "_wvalid_seen"}, 512'(io_axi_wvalid), 512'(1));
  endtask

  initial begin
    logic [63:0] a;
    reset = 1'b1;
    io_ap_start = 1'b0;
    io_start_addr = 64'd0; io_len_burst = 8'd0; io_num_burst = 32'd0; io_stride = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", 512'({io_axi_awvalid, io_axi_wvalid, io_axi_bready}), 512'(0));
    chk("rst_idle", 512'(io_ap_idle), 512'(1));
    chk("rst_ready_done", 512'({io_ap_ready, io_ap_done}), 512'(0));
    chk("rst_cnts", 512'({io_cnt_clk, io_cnt_err}), 512'(0));
    chk("rst_awaddr_wlast", 512'({io_axi_awaddr, io_axi_wlast}), 512'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic two-burst job against an always-ready slave
    bp = 1'b0; err_rand = 1'b0; err_mask = 32'd0;
    launch(64'h1000, 3, 2, 4);
    finish_run("basic");
    chk("basic_last_awaddr", 512'(last_awaddr), 512'(64'h1100));
    chk("basic_wlast_n", 512'(wlast_n), 512'(2));

    // Empty job: straight to completion
    launch({$urandom, $urandom}, 5, 0, 3);
    finish_run("empty");
    chk("empty_done_latency", 512'(done_cyc), 512'(c0 + 1));
    chk("empty_cnt_clk", 512'(io_cnt_clk), 512'(1));

    // Random backpressure, long bursts, random error responses
    bp = 1'b1; err_rand = 1'b1;
    a = {$urandom, $urandom};
    launch(a, 15, 4, $urandom_range(0, 255));
    finish_run("bp");
    chk("bp_beats64", 512'(w_k), 512'(64));

    // Errors on bursts 1 and 3 of 4
    err_rand = 1'b0; err_mask = 32'b1010;
    launch({$urandom, $urandom}, $urandom_range(0, 7), 4, $urandom_range(0, 255));
    finish_run("err");
    chk("err_cnt2", 512'(io_cnt_err), 512'(2));
    err_mask = 32'd0;

    // Start pulse and input changes while busy are ignored
    bp = 1'b0;
    launch(64'h2000_0000, 7, 3, 2);
    wait_wvalid("mid");
    @(posedge clk); #1;
    io_ap_start = 1'b1;
    io_start_addr = {$urandom, $urandom};
    io_len_burst  = 8'($urandom_range(0, 255));
    io_num_burst  = $urandom;
    io_stride     = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    io_ap_start = 1'b0;
    finish_run("midstart");

    // Reset in the middle of a data phase
    launch(64'h4000, 15, 2, 1);
    wait_wvalid("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_wvalid", 512'(io_axi_wvalid), 512'(0));
    chk("midrst_aw_b", 512'({io_axi_awvalid, io_axi_bready}), 512'(0));
    chk("midrst_idle", 512'(io_ap_idle), 512'(1));
    chk("midrst_cnts", 512'({io_cnt_clk, io_cnt_err}), 512'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    slv_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_quiet", 512'({io_axi_awvalid, io_axi_wvalid, io_ap_idle}), 512'(1));

    // Zero stride, single-beat bursts
    a = {$urandom, $urandom};
    launch(a, 0, 3, 0);
    finish_run("stride0");
    chk("stride0_addr", 512'(last_awaddr), 512'(a));
    chk("stride0_wlast_n", 512'(wlast_n), 512'(3));

    // A few fully random jobs
    bp = 1'b1; err_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      launch({$urandom, $urandom}, $urandom_range(0, 7), $urandom_range(1, 5),
             $urandom_range(0, 255));
      finish_run("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
